// File: rtl/fifo_reader.sv
// Prefetching reader: pulls words from an upstream FIFO into a two-entry output buffer and presents them as a valid/ready stream.
// Optional macro FIFO_RD_CNT_EN adds the rd_count port, which counts the beats accepted downstream.
module fifo_reader #(
  parameter int DW        = 8,
  parameter int DEPTH_OUT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_data,
  input  logic          flush,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]   rd_count
`endif
);

  localparam logic [2:0] OCC_MAX = 3'(DEPTH_OUT);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          pend;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic          pop;
  logic          cap;
  logic [2:0]    fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // A read is only issued if the buffer can still hold it once every in-flight word has landed.
  always_comb begin
    m_valid    = (state != EMPTY);
    pop        = m_valid && m_ready;
    cap        = pend && !flush;
    fill       = 3'(state) + {2'b00, pend} - {2'b00, pop};
    fifo_rd_en = !reset && !fifo_empty && !flush && (fill < OCC_MAX);
    state_nxt  = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (cap) state_nxt = ONE;
        ONE: begin
          if (cap && !pop)      state_nxt = TWO;
          else if (!cap && pop) state_nxt = EMPTY;
        end
        TWO:     if (pop && !cap) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // The head register feeds m_data directly; the tail only holds the second word while the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      head <= '0;
      tail <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (!flush) begin
        case (state)
          EMPTY: if (cap) head <= fifo_data;
          ONE: begin
            if (cap && pop) head <= fifo_data;
            else if (cap)   tail <= fifo_data;
          end
          TWO: begin
            if (pop) begin
              head <= tail;
              if (cap) tail <= fifo_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign m_data = head;

`ifdef FIFO_RD_CNT_EN
  // A beat presented in the flush cycle is not counted as accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               rd_count <= 16'd0;
    else if (pop && !flush)  rd_count <= rd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: upstream FIFO model, directed scenarios and an output scoreboard.
// Define FIFO_RD_CNT_EN to also exercise the rd_count wrap scenario.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'hEE;
  logic       flush;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr = 8'd0;
  logic       free_run;
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign fifo_empty = !free_run && (wr_ptr == rd_ptr);

  fifo_reader #(.DW(8), .DEPTH_OUT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  // Upstream FIFO: read data appears the cycle after a sampled strobe, junk otherwise.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (free_run) begin
        fifo_data <= 8'hA5;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 8'd1;
      end
    end else begin
      fifo_data <= 8'hEE;
    end
  end

  // Scoreboard monitor: every accepted beat must match the oldest expected word.
  always @(negedge clk) begin
    logic [7:0] exp_word;
    if (!reset && !free_run && !flush && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat_unexpected: got %0h, required no beat", m_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (m_data !== exp_word) begin
          errors++;
          $display("[TB] FAIL beat_data: got %0h, required %0h", m_data, exp_word);
        end
      end
    end
  end

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit expect_out);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) apply_stimulus();
    check_output(name, exp_q.size(), 0);
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] en_tab;
    logic [5:0] val_tab;
    logic [7:0] start_ptr;

    reset    = 1'b1;
    flush    = 1'b0;
    m_ready  = 1'b0;
    free_run = 1'b0;
    wr_ptr   = 8'd0;
    #2;
    check_output("reset_m_valid", m_valid, 0);
    check_output("reset_m_data", m_data, 0);
    push(8'h11, 1);
    push(8'h12, 1);
    push(8'h13, 1);
    #1;
    check_output("reset_rd_en_held_low", fifo_rd_en, 0);
    apply_stimulus();
    apply_stimulus();
    m_ready = 1'b1;
    reset   = 1'b0;

    // Three queued words, downstream always ready.
    en_tab  = 6'b000111;
    val_tab = 6'b011100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output($sformatf("s1_rd_en_c%0d", i), fifo_rd_en, en_tab[i]);
      check_output($sformatf("s1_m_valid_c%0d", i), m_valid, val_tab[i]);
    end

    // Downstream stalled with four queued words: buffer fills and reading stops.
    apply_stimulus();
    m_ready   = 1'b0;
    start_ptr = rd_ptr;
    push(8'h11, 1);
    push(8'h12, 1);
    push(8'h13, 1);
    push(8'h14, 1);
    en_tab  = 6'b000011;
    val_tab = 6'b111100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output($sformatf("s2_rd_en_c%0d", i), fifo_rd_en, en_tab[i]);
      check_output($sformatf("s2_m_valid_c%0d", i), m_valid, val_tab[i]);
      if (i >= 2) check_output($sformatf("s2_m_data_c%0d", i), m_data, 8'h11);
    end
    check_output("s2_reads_issued", rd_ptr - start_ptr, 2);

    // Asynchronous reset with a full buffer drops both buffered words.
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_m_valid", m_valid, 0);
    check_output("async_reset_rd_en", fifo_rd_en, 0);
    check_output("async_reset_m_data", m_data, 0);
    exp_q.delete();
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h14);
    apply_stimulus();
    apply_stimulus();
    reset = 1'b0;

    // Toggling ready: order preserved, nothing lost or duplicated.
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i), 1);
    for (int i = 0; i < 40; i++) begin
      m_ready = i[0];
      apply_stimulus();
    end
    m_ready = 1'b1;
    wait_drain("s3_drain");
    apply_stimulus();
    apply_stimulus();
    check_output("s3_idle_m_valid", m_valid, 0);

    // Flush the cycle after a read: the returning word is discarded.
    push(8'h55, 0);
    @(negedge clk);
    check_output("s4_rd_issue", fifo_rd_en, 1);
    apply_stimulus();
    flush = 1'b1;
    #1;
    check_output("s4_flush_rd_en", fifo_rd_en, 0);
    apply_stimulus();
    flush = 1'b0;
    push(8'h66, 1);
    @(negedge clk);
    check_output("s4_after_flush_m_valid", m_valid, 0);
    check_output("s4_read_resumes", fifo_rd_en, 1);
    wait_drain("s4_drain");

    // Flush with a full buffer.
    apply_stimulus();
    m_ready = 1'b0;
    push(8'h77, 0);
    push(8'h78, 0);
    repeat (4) apply_stimulus();
    check_output("s5_full_m_valid", m_valid, 1);
    flush = 1'b1;
    apply_stimulus();
    flush = 1'b0;
    @(negedge clk);
    check_output("s5_after_flush_m_valid", m_valid, 0);
    apply_stimulus();
    m_ready = 1'b1;
    push(8'h99, 1);
    wait_drain("s5_drain");

`ifdef FIFO_RD_CNT_EN
    // Beat counter: 2^16-2 beats then three more wraps to 1.
    apply_stimulus();
    m_ready = 1'b0;
    reset   = 1'b1;
    #1;
    check_output("cnt_reset", rd_count, 0);
    apply_stimulus();
    reset    = 1'b0;
    free_run = 1'b1;
    repeat (4) apply_stimulus();
    check_output("cnt_full_m_valid", m_valid, 1);
    m_ready = 1'b1;
    repeat (65534) apply_stimulus();
    m_ready = 1'b0;
    check_output("cnt_preload", rd_count, 16'hFFFE);
    m_ready = 1'b1;
    repeat (3) apply_stimulus();
    m_ready = 1'b0;
    check_output("cnt_wrap", rd_count, 16'h0001);
    free_run = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH_OUT, default 2, giving the output buffer entries; only the value 2 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: the upstream FIFO is empty.
REQ-006 The block SHALL have port fifo_rd_en, output, 1 bit: read strobe to the upstream FIFO.
REQ-007 The block SHALL have port fifo_data, input, DW bits: FIFO read data, valid the cycle after a sampled fifo_rd_en.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered and in-flight data.
REQ-009 The block SHALL have port m_data, output, DW bits: output stream data.
REQ-010 The block SHALL have port m_valid, output, 1 bit: m_data holds a valid beat.
REQ-011 The block SHALL have port m_ready, input, 1 bit: the downstream accepts the beat.
REQ-012 The block SHALL have port rd_count, output, 16 bits, present only under FIFO_RD_CNT_EN: count of accepted output beats.

Function
REQ-013 fifo_rd_en SHALL equal !fifo_empty && !flush && (occ + pend - pop) < 2, where:
- occ = buffer entries (0..2);
- pend = 1 if fifo_rd_en was asserted last cycle and not flushed;
- pop = m_valid && m_ready.
REQ-014 The block SHALL capture fifo_data into the buffer tail exactly one cycle after each fifo_rd_en with pend=1; a captured word is never lost or duplicated.
REQ-015 m_valid SHALL equal (occ != 0), and m_data SHALL be the buffer head, driven from a register.
REQ-016 A beat SHALL transfer when m_valid && m_ready; the head then advances the next cycle.
REQ-017 While m_valid=1 and m_ready=0, m_data SHALL stay stable.
REQ-018 Sustained !fifo_empty with m_ready=1 SHALL yield one beat per cycle after a 2-cycle initial latency from the first fifo_rd_en to m_valid.
REQ-019 On a capture and a pop in the same cycle, occ SHALL be unchanged and order preserved (FIFO order, oldest first).
REQ-020 The block SHALL never let occ exceed 2, and it SHALL never pop when occ = 0.
REQ-021 The control FSM SHALL use the following states and transitions:
- EMPTY (occ=0), ONE (occ=1) and TWO (occ=2), with transitions by capture/pop per REQ-014/016;
- TWO→ONE on pop without capture;
- ONE→TWO on capture without pop.
REQ-022 flush=1 SHALL:
- force fifo_rd_en=0 the same cycle;
- next cycle give occ=0, pend=0 and m_valid=0;
- discard any data arriving that next cycle from an earlier read;
- not count the flush-cycle pop in rd_count.
REQ-023 The block SHALL ignore fifo_data whenever pend=0.

Reset
REQ-024 Asserting reset SHALL immediately set occ=0, pend=0, m_valid=0, m_data=0 and rd_count=0, and fifo_rd_en SHALL be 0 while reset=1.
REQ-025 Reset mid-transfer SHALL drop all buffered and in-flight words, with no FIFO read issued until the first edge after deassertion.
REQ-026 The block SHALL resume normal operation on the first rising clk after reset deasserts.

Configuration
REQ-027 With macro FIFO_RD_CNT_EN defined, rd_count SHALL exist and increment by 1 on each transferred beat, wrapping from 16'hFFFF to 0.
REQ-028 With FIFO_RD_CNT_EN undefined, the rd_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario: FIFO holding 8'h11, 8'h12, 8'h13, m_ready=1 -> fifo_rd_en high 3 cycles, then m_data 11/12/13 on consecutive cycles, then m_valid=0.
REQ-030 Scenario: m_ready=0, FIFO holding 4 words -> exactly 2 reads issued, m_valid=1, m_data=8'h11 held stable, fifo_rd_en low thereafter.
REQ-031 Scenario: m_ready toggling 1/0 with a non-empty FIFO -> no loss or duplication, output order equals write order.
REQ-032 Scenario: flush pulsed the cycle after fifo_rd_en -> next cycle m_valid=0, the returning word is discarded, and reading resumes the cycle after.
REQ-033 Scenario: reset asserted with occ=2 -> m_valid=0 and fifo_rd_en=0 immediately, without waiting for clk.
REQ-034 Scenario: with FIFO_RD_CNT_EN and rd_count preloaded to 16'hFFFE via 2^16-2 beats, 3 more beats -> rd_count=1.
